// File: rtl/alu_pkg.sv
// Shared widths and opcode encoding for the registered 4-bit signed ALU.
// Imported by the combinational core and the registered top.
package alu_pkg;

    localparam int OP_W  = 2;
    localparam int IN_W  = 4;
    localparam int OUT_W = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INV = 2'b10,
        OP_ROR = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational next-result logic for the ALU; operands are sign-extended to the
// result width first, so no operation can overflow.
module alu_core
    import alu_pkg::*;
(
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic [OP_W-1:0]  Opcode,
    output logic [OUT_W-1:0] result,
    output logic             resultValid
);

    logic [OUT_W-1:0] aExt;
    logic [OUT_W-1:0] bExt;

    assign aExt = {A[IN_W-1], A};
    assign bExt = {B[IN_W-1], B};

    // An unknown opcode lands in default and tells the register to hold its value.
    always_comb begin
        result      = '0;
        resultValid = 1'b1;
        case (Opcode)
            OP_ADD:  result = aExt + bExt;
            OP_SUB:  result = aExt - bExt;
            OP_INV:  result = ~aExt;
            OP_ROR:  result = {{(OUT_W-1){1'b0}}, |B};
            default: resultValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one flop stage on the core's result with an asynchronous
// active-high clear.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  Opcode,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    output logic [OUT_W-1:0] C
);

    logic [OUT_W-1:0] coreResult;
    logic             coreValid;
    logic [OUT_W-1:0] result_d;
    logic [OUT_W-1:0] result_q;

    alu_core u_core (
        .A           (A),
        .B           (B),
        .Opcode      (Opcode),
        .result      (coreResult),
        .resultValid (coreValid)
    );

    assign result_d = coreValid ? coreResult : result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign C = result_q;

    // Sanity checks on every opcode and on the operand/result extremes.
    always @(posedge clk) begin
        if (!reset && coreValid) begin
            if (Opcode == OP_ROR)
                assert (coreResult[OUT_W-1:1] == '0) else $error("ROR upper bits set");
            if (Opcode == OP_INV)
                assert (coreResult == ~{A[IN_W-1], A}) else $error("INV result wrong");
            if (Opcode == OP_ADD && A == 4'sd7 && B == 4'sd7)
                assert (coreResult == 5'sd14) else $error("ADD 7+7 wrong");
            if (Opcode == OP_ADD && A == 4'b1000 && B == 4'b1000)
                assert (coreResult == 5'b10000) else $error("ADD -8+-8 wrong");
            if (Opcode == OP_SUB && A == 4'sd7 && B == 4'b1000)
                assert (coreResult == 5'sd15) else $error("SUB 7-(-8) wrong");
            if (Opcode == OP_SUB && A == 4'b0000 && B == 4'b0000)
                assert (coreResult == '0) else $error("SUB 0-0 wrong");
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector and randomized bench for the registered ALU, including
// asynchronous reset behaviour.
module tb_alu;

    logic       clk;
    logic       reset;
    logic [1:0] Opcode;
    logic [3:0] A;
    logic [3:0] B;
    logic [4:0] C;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] op;
        int         a;
        int         b;
        int         expC;
        string      name;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clk    (clk),
        .reset  (reset),
        .Opcode (Opcode),
        .A      (A),
        .B      (B),
        .C      (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int refModel(input logic [1:0] op, input int a, input int b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return -a - 1;
            default: return (b != 0) ? 1 : 0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input int a, input int b);
        Opcode = op;
        A      = a[3:0];
        B      = b[3:0];
    endtask

    task automatic compareNow(input string name, input int expC);
        int actual;
        actual = int'($signed(C));
        checks++;
        if (actual !== expC) begin
            errors++;
            $display("[TB] FAIL %s: C=%0d expected %0d", name, actual, expC);
        end
    endtask

    task automatic checkOutput(input string name, input int expC);
        @(negedge clk);
        compareNow(name, expC);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(2'b00, 5, 3);

        vecs.push_back('{2'b00,  7,  7,  14, "add_7_7"});
        vecs.push_back('{2'b00, -8, -8, -16, "add_m8_m8"});
        vecs.push_back('{2'b00, -3,  2,  -1, "add_m3_2"});
        vecs.push_back('{2'b00,  0,  0,   0, "add_0_0"});
        vecs.push_back('{2'b01,  7, -8,  15, "sub_7_m8"});
        vecs.push_back('{2'b01, -8,  7, -15, "sub_m8_7"});
        vecs.push_back('{2'b01,  4,  4,   0, "sub_4_4"});
        vecs.push_back('{2'b10,  0,  5,  -1, "inv_0"});
        vecs.push_back('{2'b10, -8,  0,   7, "inv_m8"});
        vecs.push_back('{2'b10,  3, -8,  -4, "inv_3_bm8"});
        vecs.push_back('{2'b10,  3,  7,  -4, "inv_3_b7"});
        vecs.push_back('{2'b11,  5,  0,   0, "ror_b0"});
        vecs.push_back('{2'b11, -8, -8,   1, "ror_bm8"});
        vecs.push_back('{2'b11,  7,  1,   1, "ror_b1"});
        vecs.push_back('{2'b11, -1,  0,   0, "ror_b0_am1"});

        // Reset takes effect between edges and holds through clocks.
        #2 reset = 1'b1;
        #1 compareNow("reset_async", 0);
        checkOutput("reset_hold1", 0);
        checkOutput("reset_hold2", 0);
        reset = 1'b0;
        checkOutput("reset_release", 8);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput(vecs[i].name, vecs[i].expC);
        end

        // Mid-stream reset drops C without a clock edge.
        applyStimulus(2'b00, 2, 3);
        checkOutput("mid_add", 5);
        #2 reset = 1'b1;
        #1 compareNow("mid_reset_async", 0);
        checkOutput("mid_reset_hold", 0);
        reset = 1'b0;
        checkOutput("mid_reset_release", 5);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int a;
            int b;
            op = 2'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 15)) - 8;
            b  = int'($urandom_range(0, 15)) - 8;
            applyStimulus(op, a, b);
            checkOutput("random", refModel(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
